// File: rtl/cursor_move.sv
// Cursor position controller: debounces four direction buttons and steps the cursor on a 64x64 grid.
// Edge behaviour selected by CURSOR_WRAP_EN (defined: wrap around, undefined: clamp at 0/63).
module cursor_move #(
  parameter int DB_CYCLES = 50000,
  parameter int X_INIT    = 32,
  parameter int Y_INIT    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       cursor_done,
  output logic [5:0] cur_x,
  output logic [5:0] cur_y,
  output logic       draw_init,
  output logic       busy
);

  typedef enum logic [2:0] {S_BOOT, S_IDLE, S_MOVE, S_START, S_WAIT} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  localparam logic [15:0] DB_LAST = 16'(DB_CYCLES - 1);

  // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right
  logic [3:0]  btn_raw;
  logic [3:0]  sync1, sync2;
  logic [3:0]  db_level, db_prev, press;
  logic [15:0] db_cnt [4];

  state_t state, next_state;
  dir_t   dir_q, dir_next, pri_dir;
  logic [5:0] mv_x, mv_y;
  logic       moved;

  assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

  // The counter only runs while the synchronized input disagrees with the debounced level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= ~db_level[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev <= '0;
      press   <= '0;
    end else begin
      db_prev <= db_level;
      press   <= db_level & ~db_prev;
    end
  end

  always_comb begin
    pri_dir = DIR_RIGHT;
    if (press[3])      pri_dir = DIR_UP;
    else if (press[2]) pri_dir = DIR_DOWN;
    else if (press[1]) pri_dir = DIR_LEFT;
  end

  // In clamp mode a move off the edge leaves the coordinate alone, which MOVE reads as "no draw"
  always_comb begin
    mv_x = cur_x;
    mv_y = cur_y;
    case (dir_q)
      DIR_UP:    if (WRAP || cur_y != 6'd0)  mv_y = cur_y - 6'd1;
      DIR_DOWN:  if (WRAP || cur_y != 6'd63) mv_y = cur_y + 6'd1;
      DIR_LEFT:  if (WRAP || cur_x != 6'd0)  mv_x = cur_x - 6'd1;
      DIR_RIGHT: if (WRAP || cur_x != 6'd63) mv_x = cur_x + 6'd1;
      default: ;
    endcase
    moved = (mv_x != cur_x) || (mv_y != cur_y);
  end

  always_comb begin
    next_state = state;
    dir_next   = dir_q;
    case (state)
      S_BOOT:  next_state = S_START;
      S_IDLE: begin
        if (enable && (press != 4'b0000)) begin
          next_state = S_MOVE;
          dir_next   = pri_dir;
        end
      end
      S_MOVE:  next_state = moved ? S_START : S_IDLE;
      S_START: next_state = S_WAIT;
      S_WAIT:  if (cursor_done) next_state = S_IDLE;
      default: next_state = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
      dir_q <= DIR_UP;
      cur_x <= 6'(X_INIT);
      cur_y <= 6'(Y_INIT);
    end else begin
      state <= next_state;
      dir_q <= dir_next;
      if (state == S_MOVE) begin
        cur_x <= mv_x;
        cur_y <= mv_y;
      end
    end
  end

  assign draw_init = (state == S_START);
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_cursor_move.sv
// Testbench for cursor_move: scoreboard of expected draw coordinates checked on each draw_init.
// Honours CURSOR_WRAP_EN the same way as the design.
module tb_cursor_move;

  localparam int DB = 4;

`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, enable, cursor_done;
  logic       btn_up, btn_down, btn_left, btn_right;
  logic [5:0] cur_x, cur_y;
  logic       draw_init, busy;

  int checks = 0;
  int passed = 0;
  int draw_count = 0;
  int model_x, model_y;
  logic [11:0] sb_q[$];
  logic [11:0] mon_exp;

  cursor_move #(.DB_CYCLES(DB), .X_INIT(32), .Y_INIT(32)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .cursor_done(cursor_done),
    .cur_x(cur_x), .cur_y(cur_y), .draw_init(draw_init), .busy(busy)
  );

  always #5 clk = ~clk;

  // Every draw must match the oldest expected coordinate pair
  always @(negedge clk) begin
    if (draw_init === 1'b1) begin
      draw_count++;
      checks++;
      if (sb_q.size() == 0) begin
        $display("[TB] FAIL draw_unexpected: got draw at (%0d,%0d), required no draw", cur_x, cur_y);
      end else begin
        mon_exp = sb_q.pop_front();
        if ({cur_x, cur_y} !== mon_exp)
          $display("[TB] FAIL draw_coord: got (%0d,%0d), required (%0d,%0d)",
                   cur_x, cur_y, mon_exp[11:6], mon_exp[5:0]);
        else passed++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no end of test, required finish before 1ms");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_up, btn_down, btn_left, btn_right} = m;
  endtask

  task automatic wait_draw(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (draw_init === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic send_done(input int delay);
    repeat (delay) @(posedge clk);
    #1 cursor_done = 1'b1;
    @(posedge clk);
    #1 cursor_done = 1'b0;
  endtask

  // dir: 0 up, 1 down, 2 left, 3 right; pushes the expected draw when the position changes
  task automatic model_step(input int dir, output bit changed);
    int nx = model_x;
    int ny = model_y;
    case (dir)
      0: ny = WRAP ? (ny + 63) % 64 : (ny == 0  ? 0  : ny - 1);
      1: ny = WRAP ? (ny + 1) % 64  : (ny == 63 ? 63 : ny + 1);
      2: nx = WRAP ? (nx + 63) % 64 : (nx == 0  ? 0  : nx - 1);
      default: nx = WRAP ? (nx + 1) % 64 : (nx == 63 ? 63 : nx + 1);
    endcase
    changed = (nx != model_x) || (ny != model_y);
    model_x = nx;
    model_y = ny;
    if (changed) sb_q.push_back({6'(nx), 6'(ny)});
  endtask

  task automatic press_move(input int dir, input int done_delay, output bit seen);
    bit ch;
    logic [3:0] m;
    model_step(dir, ch);
    m = 4'b1000 >> dir;
    set_btns(m);
    wait_draw(40, seen);
    if (seen) send_done(done_delay);
    set_btns(4'b0000);
    tick(12);
  endtask

  task automatic test_reset();
    bit stayed_busy;
    rst = 1'b1; enable = 1'b1; cursor_done = 1'b0;
    set_btns(4'b0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (cur_x !== 6'd32) $display("[TB] FAIL reset_x: got %0d, required 32", cur_x); else passed++;
    checks++; if (cur_y !== 6'd32) $display("[TB] FAIL reset_y: got %0d, required 32", cur_y); else passed++;
    checks++; if (draw_init !== 1'b0) $display("[TB] FAIL reset_draw: got %b, required 0", draw_init); else passed++;
    checks++; if (busy !== 1'b1) $display("[TB] FAIL reset_busy: got %b, required 1", busy); else passed++;
    model_x = 32; model_y = 32;
    sb_q.push_back({6'd32, 6'd32});
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (draw_init !== 1'b0) $display("[TB] FAIL boot_draw: got %b, required 0", draw_init); else passed++;
    @(negedge clk);
    checks++; if (draw_init !== 1'b1) $display("[TB] FAIL start_draw: got %b, required 1", draw_init); else passed++;
    @(negedge clk);
    checks++; if (draw_init !== 1'b0) $display("[TB] FAIL draw_width: got %b, required 0", draw_init); else passed++;
    stayed_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) stayed_busy = 1'b0;
    end
    checks++; if (stayed_busy !== 1'b1) $display("[TB] FAIL wait_busy: got %b, required 1", stayed_busy); else passed++;
    send_done(1);
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL done_idle: got busy %b, required 0", busy); else passed++;
  endtask

  task automatic test_move_right();
    bit seen;
    int d0 = draw_count;
    press_move(3, 5, seen);
    checks++; if (seen !== 1'b1) $display("[TB] FAIL right_draw: got %b, required 1", seen); else passed++;
    checks++; if (cur_x !== 6'd33) $display("[TB] FAIL right_x: got %0d, required 33", cur_x); else passed++;
    checks++; if (draw_count - d0 !== 1) $display("[TB] FAIL right_count: got %0d, required 1", draw_count - d0); else passed++;
    set_btns(4'b0010);
    tick(2);
    set_btns(4'b0000);
    tick(20);
    checks++; if (cur_x !== 6'd33) $display("[TB] FAIL glitch_x: got %0d, required 33", cur_x); else passed++;
    checks++; if (draw_count - d0 !== 1) $display("[TB] FAIL glitch_count: got %0d, required 1", draw_count - d0); else passed++;
  endtask

  task automatic test_priority();
    bit seen, ch;
    int d0;
    press_move(2, 1, seen);
    checks++; if (seen !== 1'b1) $display("[TB] FAIL left_draw: got %b, required 1", seen); else passed++;
    d0 = draw_count;
    model_step(0, ch);
    set_btns(4'b1010);
    wait_draw(40, seen);
    if (seen) send_done(2);
    set_btns(4'b0000);
    tick(15);
    checks++; if (seen !== 1'b1) $display("[TB] FAIL prio_draw: got %b, required 1", seen); else passed++;
    checks++; if (cur_y !== 6'd31) $display("[TB] FAIL prio_y: got %0d, required 31", cur_y); else passed++;
    checks++; if (cur_x !== 6'd32) $display("[TB] FAIL prio_x: got %0d, required 32", cur_x); else passed++;
    checks++; if (draw_count - d0 !== 1) $display("[TB] FAIL prio_count: got %0d, required 1", draw_count - d0); else passed++;
  endtask

  task automatic test_edge();
    bit seen;
    int errs = 0;
    int d0;
    for (int i = 0; i < 31; i++) begin
      press_move(3, 1, seen);
      if (!seen) errs++;
    end
    for (int i = 0; i < 31; i++) begin
      press_move(0, 1, seen);
      if (!seen) errs++;
    end
    checks++; if (errs !== 0) $display("[TB] FAIL walk_draws: got %0d missing, required 0", errs); else passed++;
    checks++; if ({cur_x, cur_y} !== {6'd63, 6'd0})
      $display("[TB] FAIL corner: got (%0d,%0d), required (63,0)", cur_x, cur_y); else passed++;
    d0 = draw_count;
`ifdef CURSOR_WRAP_EN
    press_move(3, 1, seen);
    checks++; if ({seen, cur_x, cur_y} !== {1'b1, 6'd0, 6'd0})
      $display("[TB] FAIL wrap_right: got draw %b at (%0d,%0d), required draw at (0,0)", seen, cur_x, cur_y); else passed++;
    press_move(0, 1, seen);
    checks++; if ({seen, cur_x, cur_y} !== {1'b1, 6'd0, 6'd63})
      $display("[TB] FAIL wrap_up: got draw %b at (%0d,%0d), required draw at (0,63)", seen, cur_x, cur_y); else passed++;
    checks++; if (draw_count - d0 !== 2) $display("[TB] FAIL wrap_count: got %0d, required 2", draw_count - d0); else passed++;
`else
    for (int k = 0; k < 2; k++) begin
      bit found = 1'b0;
      set_btns(k == 0 ? 4'b0001 : 4'b1000);
      for (int i = 0; i < 40 && !found; i++) begin
        @(negedge clk);
        if (busy === 1'b1) found = 1'b1;
      end
      @(negedge clk);
      checks++; if ({found, busy} !== 2'b10)
        $display("[TB] FAIL clamp_busy%0d: got found %b busy %b, required found 1 busy 0", k, found, busy); else passed++;
      set_btns(4'b0000);
      tick(12);
    end
    checks++; if ({cur_x, cur_y} !== {6'd63, 6'd0})
      $display("[TB] FAIL clamp_pos: got (%0d,%0d), required (63,0)", cur_x, cur_y); else passed++;
    checks++; if (draw_count - d0 !== 0) $display("[TB] FAIL clamp_count: got %0d, required 0", draw_count - d0); else passed++;
`endif
  endtask

  task automatic test_discard();
    bit seen, ch, any_busy;
    int d0 = draw_count;
    model_step(2, ch);
    set_btns(4'b0010);
    wait_draw(40, seen);
    checks++; if (seen !== 1'b1) $display("[TB] FAIL discard_draw: got %b, required 1", seen); else passed++;
    set_btns(4'b0100);
    tick(12);
    set_btns(4'b0000);
    tick(12);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL wait_hold: got busy %b, required 1", busy); else passed++;
    send_done(1);
    tick(10);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL discard_idle: got busy %b, required 0", busy); else passed++;
    checks++; if (cur_y !== 6'(model_y)) $display("[TB] FAIL discard_y: got %0d, required %0d", cur_y, model_y); else passed++;
    checks++; if (draw_count - d0 !== 1) $display("[TB] FAIL discard_count: got %0d, required 1", draw_count - d0); else passed++;
    enable = 1'b0;
    any_busy = 1'b0;
    set_btns(4'b0100);
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (busy !== 1'b0) any_busy = 1'b1;
    end
    set_btns(4'b0000);
    tick(12);
    enable = 1'b1;
    checks++; if (any_busy !== 1'b0) $display("[TB] FAIL disabled_busy: got %b, required 0", any_busy); else passed++;
    checks++; if (cur_y !== 6'(model_y)) $display("[TB] FAIL disabled_y: got %0d, required %0d", cur_y, model_y); else passed++;
  endtask

  task automatic test_reset_mid();
    bit seen, ch;
    int errs = 0;
    sb_q.push_back({6'd32, 6'd32});
    model_x = 32; model_y = 32;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    wait_draw(10, seen);
    if (seen) send_done(1);
    tick(3);
    checks++; if (seen !== 1'b1) $display("[TB] FAIL rearm_draw: got %b, required 1", seen); else passed++;
    for (int i = 0; i < 8; i++) begin
      press_move(3, 1, seen);
      if (!seen) errs++;
    end
    for (int i = 0; i < 21; i++) begin
      press_move(0, 1, seen);
      if (!seen) errs++;
    end
    model_step(0, ch);
    set_btns(4'b1000);
    wait_draw(40, seen);
    if (!seen) errs++;
    tick(3);
    checks++; if ({busy, cur_x, cur_y} !== {1'b1, 6'd40, 6'd10})
      $display("[TB] FAIL pre_reset: got busy %b (%0d,%0d), required busy 1 (40,10)", busy, cur_x, cur_y); else passed++;
    checks++; if (errs !== 0) $display("[TB] FAIL walk2_draws: got %0d missing, required 0", errs); else passed++;
    rst = 1'b1;
    #1;
    checks++; if ({cur_x, cur_y, draw_init, busy} !== {6'd32, 6'd32, 1'b0, 1'b1})
      $display("[TB] FAIL mid_reset: got (%0d,%0d) draw %b busy %b, required (32,32) draw 0 busy 1",
               cur_x, cur_y, draw_init, busy); else passed++;
    set_btns(4'b0000);
    sb_q.push_back({6'd32, 6'd32});
    model_x = 32; model_y = 32;
    tick(2);
    rst = 1'b0;
    wait_draw(10, seen);
    if (seen) send_done(1);
    tick(3);
    checks++; if ({seen, busy} !== 2'b10) $display("[TB] FAIL redraw: got draw %b busy %b, required draw 1 busy 0", seen, busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_move_right();
    test_priority();
    test_edge();
    test_discard();
    test_reset_mid();
    checks++;
    if (sb_q.size() !== 0) $display("[TB] FAIL pending_draws: got %0d outstanding, required 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cursor_move.md
# cursor_move

Upstream controller for the cursor drawer. It converts four raw direction buttons into debounced press events and keeps the cursor position on the 64x64 grid. On each accepted move it hands the new coordinates to the cursor-draw stage with a one-cycle `draw_init` pulse, then holds until that stage reports `cursor_done`.

## Interface
- `DB_CYCLES`, default 50000: consecutive stable cycles required before a button's debounced level changes. Range 1..65535.
- `X_INIT`, default 32: cursor column after reset, 0..63.
- `Y_INIT`, default 32: cursor row after reset, 0..63.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when 0, press events are dropped in IDLE.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  raw, asynchronous, active-high buttons.
- `cursor_done`  in  1  completion strobe from the cursor-draw stage.
- `cur_x`  out  6  cursor column, driven to the drawer's `in_x`.
- `cur_y`  out  6  cursor row, driven to the drawer's `in_y`; row 0 is the top row.
- `draw_init`  out  1  one-cycle start pulse to the drawer's `init`.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- Each button passes through a 2-flop synchronizer, then its own 16-bit debounce counter.
  - The counter clears whenever the synchronized level equals the debounced level, and increments otherwise.
  - When the counter reaches `DB_CYCLES`, the debounced level toggles and the counter clears.
  - A registered rising edge of the debounced level is a one-cycle press event. Releases generate no event.
- FSM states are BOOT, IDLE, MOVE, START and WAIT.
  - BOOT -> START, unconditionally. This draws the initial cursor after reset.
  - IDLE -> MOVE when `enable`=1 and at least one press event is present. The move direction is latched at this point.
  - Simultaneous events resolve by priority up > down > left > right. Lower-priority events are discarded.
  - Events arriving in any state other than IDLE are discarded, not queued.
  - MOVE applies the move: up is `cur_y`-1, down is `cur_y`+1, left is `cur_x`-1, right is `cur_x`+1.
  - MOVE -> START if the coordinate changed. It goes back to IDLE if the coordinate did not change (edge clamp, see Configuration).
  - START asserts `draw_init`, then goes to WAIT.
  - WAIT -> IDLE on `cursor_done`=1. `cursor_done` is ignored in every other state.
- `cur_x`/`cur_y` change only on the MOVE clock edge. They are stable from START through the end of WAIT.
- Arithmetic is 6-bit unsigned. Boundary handling at 0 and 63 is set by the macro under Configuration.
- Reset mid-operation (any state) forces the reset values below at once.
  - The FSM then restarts through BOOT/START, so the cursor is redrawn at (`X_INIT`,`Y_INIT`).

## Timing
- Reset values:
  - `cur_x`=`X_INIT`, `cur_y`=`Y_INIT`.
  - `draw_init`=0, `busy`=1 (state BOOT).
  - Synchronizers, debounced levels and counters all 0.
- First cycle after reset release: BOOT. Second cycle: START, with `draw_init`=1.
- Press path:
  - Raw edge to press event is 2 synchronizer cycles + `DB_CYCLES` + 1 edge cycle.
  - Event in IDLE at cycle N: MOVE at N+1, new coordinates visible and `draw_init`=1 at N+2, WAIT from N+3.
- `draw_init` = (state==START). It is exactly one cycle wide per draw.
- `busy` = (state!=IDLE), decoded combinationally from the state register.
- `cursor_done` seen in WAIT at cycle M: IDLE at M+1. A new event can be accepted at M+1.
- `enable` is sampled only in IDLE. Deasserting it in MOVE, START or WAIT does not abort the draw.

## Configuration
- `CURSOR_WRAP_EN` defined: moves wrap around.
  - 0-1 gives 63, 63+1 gives 0, on either axis.
  - MOVE always changes the coordinate and always goes to START.
- `CURSOR_WRAP_EN` undefined: moves clamp at the edge.
  - A move past 0 or 63 leaves the coordinate unchanged.
  - MOVE then returns to IDLE, with no `draw_init` pulse.

## Test plan
All scenarios use `DB_CYCLES`=4.
1. Reset release -> BOOT, then `draw_init`=1 for exactly one cycle on the 2nd cycle, with `cur_x`=32, `cur_y`=32. Hold `cursor_done`=0 -> `busy` stays 1. Pulse `cursor_done` -> `busy`=0 one cycle later.
2. `btn_right` held 20 cycles, drawer answers `cursor_done` 5 cycles after `draw_init` -> `cur_x`=33, one `draw_init` pulse. A 2-cycle glitch on `btn_left` -> no event, `cur_x` stays 33.
3. `btn_up` and `btn_left` rise in the same cycle from (32,32) -> `cur_y`=31, `cur_x`=32 unchanged, one draw only.
4. Cursor at (63,0), press right then up:
   - Without `CURSOR_WRAP_EN`: position stays (63,0), no `draw_init`, `busy` returns to 0 one cycle after MOVE.
   - With `CURSOR_WRAP_EN`: position becomes (0,0) then (0,63), with two draws.
5. Press `btn_down` while in WAIT (`cursor_done` withheld) -> event discarded, `cur_y` unchanged after done. With `enable`=0, a press in IDLE -> no state change.
6. Assert `rst` during WAIT after moving to (40,10) -> `cur_x`=32, `cur_y`=32, `draw_init`=0 immediately. After release, BOOT/START redraw occurs.
